bsg_cgol_sched: RTL and testbench

BSG_CGOL_SCHED -- requirements
Module: bsg_cgol_sched

---
 rtl/bsg_cgol_sched_pkg.sv | 22 ++
 rtl/bsg_cgol_rr_arb.sv | 30 +++
 rtl/bsg_cgol_sched.sv | 160 ++++++++++++++++
 tb/tb_bsg_cgol_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cgol_sched_pkg.sv
// Shared types and default parameter values for the CGOL job scheduler.
package bsg_cgol_sched_pkg;

  localparam int num_req_dp    = 2;
  localparam int data_width_dp = 64;
  localparam int in_words_dp   = 64;
  localparam int out_words_dp  = 64;
  localparam int timeout_dp    = 1048576;

  // Job lifecycle: arbitrate, stream job in, wait for engine, stream result out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } cgol_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_cgol_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer position (wrapping) wins; the grant is one-hot or all zero.
module bsg_cgol_rr_arb
  import bsg_cgol_sched_pkg::*;
#(
  parameter int num_req_p = num_req_dp,
  parameter int ptr_w_p   = 1
) (
  input  logic [num_req_p-1:0] i_req,
  input  logic [ptr_w_p-1:0]   i_rr_ptr,
  output logic [num_req_p-1:0] o_grant
);

  logic w_found;

  // Scan priority offsets from the pointer; index only with loop constants.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      for (int j = 0; j < num_req_p; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_rr_ptr) + k) % num_req_p))) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bsg_cgol_sched.sv
// Shares one CGOL engine among num_req_p requesters, one whole job at a time.
// Optional watchdog on the WAIT state: define BSG_CGOL_SCHED_TIMEOUT_EN.
// Handshakes: a word moves on a rising clock edge where the sender's valid and
// the receiver's ready (or yumi) are both high; yumi is only raised while valid.
module bsg_cgol_sched
  import bsg_cgol_sched_pkg::*;
#(
  parameter int num_req_p    = num_req_dp,
  parameter int data_width_p = data_width_dp,
  parameter int in_words_p   = in_words_dp,
  parameter int out_words_p  = out_words_dp,
  parameter int timeout_p    = timeout_dp
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_ready_o,
  output logic [num_req_p-1:0]              req_v_o,
  output logic [num_req_p*data_width_p-1:0] req_data_o,
  input  logic [num_req_p-1:0]              req_yumi_i,
  output logic                              eng_v_o,
  output logic [data_width_p-1:0]           eng_data_o,
  input  logic                              eng_ready_i,
  input  logic                              eng_v_i,
  input  logic [data_width_p-1:0]           eng_data_i,
  output logic                              eng_yumi_o,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              error_o,
  output logic [1:0]                        o_dbg_state
);

  localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w_lp = $clog2(max_int(in_words_p, out_words_p) + 1);
  localparam logic [cnt_w_lp-1:0] in_last_lp  = cnt_w_lp'(in_words_p - 1);
  localparam logic [cnt_w_lp-1:0] out_last_lp = cnt_w_lp'(out_words_p - 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(num_req_p - 1);

  cgol_state_e           r_state, w_state_next;
  logic [ptr_w_lp-1:0]   r_owner, r_rr_ptr, w_arb_idx;
  logic [num_req_p-1:0]  r_grant, w_arb_grant;
  logic [cnt_w_lp-1:0]   r_cnt;
  logic                  w_load_fire, w_drain_fire, w_load_done, w_drain_done;
  logic                  w_timeout;

  bsg_cgol_rr_arb #(.num_req_p(num_req_p), .ptr_w_p(ptr_w_lp)) u_arb (
    .i_req    (req_v_i),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant)
  );

  // Encode the one-hot arbiter result so the rr pointer can be advanced later.
  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (w_arb_grant[i]) w_arb_idx = ptr_w_lp'(i);
    end
  end

  assign w_load_fire  = eng_v_o & eng_ready_i;
  assign w_drain_fire = eng_v_i & eng_yumi_o;
  assign w_load_done  = w_load_fire  && (r_cnt == in_last_lp);
  assign w_drain_done = w_drain_fire && (r_cnt == out_last_lp);

`ifdef BSG_CGOL_SCHED_TIMEOUT_EN
  localparam int wd_w_lp = $clog2(timeout_p + 1);
  localparam logic [wd_w_lp-1:0] wd_last_lp = wd_w_lp'(timeout_p - 1);

  logic [wd_w_lp-1:0] r_wd_cnt;
  logic               r_error;

  // A result arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == WAIT) && !eng_v_i && (r_wd_cnt == wd_last_lp);

  // Watchdog counts WAIT cycles; the error flag stays set until reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state != w_state_next) r_wd_cnt <= '0;
      else if (r_state == WAIT)    r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign error_o = r_error;
`else
  assign w_timeout = 1'b0;
  // Without the watchdog timeout_p has no effect and error_o is tied low.
  assign error_o = (timeout_p < 0);
`endif

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic: a granted job runs to completion without pre-emption.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|req_v_i)     w_state_next = LOAD;
      LOAD:    if (w_load_done)  w_state_next = WAIT;
      WAIT:    if (eng_v_i)      w_state_next = DRAIN;
               else if (w_timeout) w_state_next = IDLE;
      DRAIN:   if (w_drain_done) w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  // Owner, rr pointer and word counter; the counter restarts on every state change.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_owner  <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state != w_state_next)           r_cnt <= '0;
      else if (w_load_fire || w_drain_fire) r_cnt <= r_cnt + 1'b1;

      if ((r_state == IDLE) && (|req_v_i)) begin
        r_owner <= w_arb_idx;
        r_grant <= w_arb_grant;
      end else if ((r_state != IDLE) && (w_state_next == IDLE)) begin
        r_grant  <= '0;
        r_rr_ptr <= (r_owner == ptr_last_lp) ? '0 : r_owner + 1'b1;
      end
    end
  end

  // Output steering: only the owner is connected to the engine, and only in LOAD/DRAIN.
  always_comb begin
    req_ready_o = '0;
    req_v_o     = '0;
    req_data_o  = '0;
    eng_v_o     = 1'b0;
    eng_data_o  = '0;
    eng_yumi_o  = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (r_grant[i]) begin
        if (r_state == LOAD) begin
          eng_v_o        = req_v_i[i];
          eng_data_o     = req_data_i[i*data_width_p +: data_width_p];
          req_ready_o[i] = eng_ready_i;
        end else if (r_state == DRAIN) begin
          req_v_o[i]                                = eng_v_i;
          req_data_o[i*data_width_p +: data_width_p] = eng_data_i;
          eng_yumi_o                                = eng_v_i & req_yumi_i[i];
        end
      end
    end
  end

  assign grant_o     = r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bsg_cgol_sched.sv
// Bench for bsg_cgol_sched: two requesters, 4-word jobs, 16-cycle watchdog.
// The engine model answers each input word w with w + 9 (so 1..4 -> A..D).
module tb_bsg_cgol_sched;
  import bsg_cgol_sched_pkg::*;

  typedef logic [15:0] word_t;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        v0, v1, y0, y1, eng_ready, eng_v, bp;
  word_t       d0, d1, eng_d;
  logic [1:0]  req_v_i, req_ready_o, req_v_o, req_yumi_i, grant_o, dbg_state;
  logic [31:0] req_data_i, req_data_o;
  logic        eng_v_o, eng_yumi_o, error_o;
  word_t       eng_data_o;

  assign req_v_i    = {v1, v0};
  assign req_data_i = {d1, d0};
  assign req_yumi_i = {y1, y0};

  bsg_cgol_sched #(.num_req_p(2), .data_width_p(16), .in_words_p(4),
                   .out_words_p(4), .timeout_p(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .req_v_o(req_v_o), .req_data_o(req_data_o), .req_yumi_i(req_yumi_i),
    .eng_v_o(eng_v_o), .eng_data_o(eng_data_o), .eng_ready_i(eng_ready),
    .eng_v_i(eng_v), .eng_data_i(eng_d), .eng_yumi_o(eng_yumi_o),
    .grant_o(grant_o), .error_o(error_o), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_eng_q[$];
  logic [15:0] exp_req0_q[$];
  logic [15:0] exp_req1_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed transfer against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_v_o && eng_ready) begin
        check("eng_word_expected", (exp_eng_q.size() != 0), 1);
        if (exp_eng_q.size() != 0) check("eng_word", eng_data_o, exp_eng_q.pop_front());
      end
      if (req_v_o[0] && y0) begin
        check("req0_word_expected", (exp_req0_q.size() != 0), 1);
        if (exp_req0_q.size() != 0) check("req0_word", req_data_o[15:0], exp_req0_q.pop_front());
      end
      if (req_v_o[1] && y1) begin
        check("req1_word_expected", (exp_req1_q.size() != 0), 1);
        if (exp_req1_q.size() != 0) check("req1_word", req_data_o[31:16], exp_req1_q.pop_front());
      end
      if (eng_yumi_o) check("yumi_without_valid", eng_v, 1);
      if (dbg_state != IDLE) begin
        check("ready_non_owner", req_ready_o & ~grant_o, 0);
        check("valid_non_owner", req_v_o & ~grant_o, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int r, input logic v, input word_t d);
    if (r == 0) begin v0 = v; d0 = d; end
    else        begin v1 = v; d1 = d; end
  endtask

  task automatic set_y(input int r, input logic y);
    if (r == 0) y0 = y; else y1 = y;
  endtask

  function automatic logic get_y(input int r);
    return (r == 0) ? y0 : y1;
  endfunction

  word_t rx_buf[4];

  task automatic req_send(input int r, input word_t base);
    int n;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive_req(r, 1'b1, base + word_t'(k));
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready_o[r] && n < 400);
      check("send_accept", req_ready_o[r], 1);
      check("grant_owner", grant_o, (r == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1;
    drive_req(r, 1'b0, '0);
  endtask

  task automatic eng_accept(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 400) begin
      @(posedge clk); #1;
      eng_ready = !bp || cyc[0];
      @(negedge clk); t++;
      if (eng_ready && eng_v_o) begin rx_buf[got] = eng_data_o; got++; end
    end
    @(posedge clk); #1;
    eng_ready = 1'b0;
    check("eng_rx_count", got, n);
  endtask

  task automatic eng_return(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      eng_v = 1'b1;
      eng_d = rx_buf[k] + 16'd9;
      t = 0;
      do begin @(negedge clk); t++; end while (!eng_yumi_o && t < 400);
      check("eng_yumi_seen", eng_yumi_o, 1);
    end
    @(posedge clk); #1;
    eng_v = 1'b0;
  endtask

  task automatic eng_job(input int lat);
    eng_accept(4);
    repeat (lat) @(posedge clk);
    eng_return(4);
  endtask

  task automatic req_recv(input int r, input int n);
    int count = 0;
    int t = 0;
    while (count < n && t < 400) begin
      @(posedge clk); #2;
      set_y(r, req_v_o[r] && (!bp || cyc[0]));
      @(negedge clk); t++;
      if (get_y(r) && req_v_o[r]) count++;
    end
    @(posedge clk); #2;
    set_y(r, 1'b0);
    check("recv_count", count, n);
  endtask

  task automatic push_job(input int r, input word_t base, input word_t res, input int nres);
    for (int k = 0; k < 4; k++) exp_eng_q.push_back(base + word_t'(k));
    for (int k = 0; k < nres; k++) begin
      if (r == 0) exp_req0_q.push_back(res + word_t'(k));
      else        exp_req1_q.push_back(res + word_t'(k));
    end
  endtask

  task automatic run_job(input int r, input word_t base, input word_t res);
    push_job(r, base, res, 4);
    fork
      req_send(r, base);
      eng_job(10);
      req_recv(r, 4);
    join
  endtask

  // Tie between both requesters; req0 is expected to be served first.
  task automatic run_pair(input word_t b0, input word_t r0, input word_t b1, input word_t r1);
    push_job(0, b0, r0, 4);
    push_job(1, b1, r1, 4);
    fork
      req_send(0, b0);
      req_send(1, b1);
      begin eng_job(10); eng_job(10); end
      req_recv(0, 4);
      req_recv(1, 4);
    join
  endtask

  task automatic check_idle(input logic exp_err);
    check("idle_state", dbg_state, IDLE);
    check("idle_grant", grant_o, 0);
    check("idle_req_ready", req_ready_o, 0);
    check("idle_req_v", req_v_o, 0);
    check("idle_req_data", req_data_o, 0);
    check("idle_eng_v", eng_v_o, 0);
    check("idle_eng_data", eng_data_o, 0);
    check("idle_eng_yumi", eng_yumi_o, 0);
    check("idle_error", error_o, exp_err);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; bp = 1'b0;
    v0 = 1'b1; v1 = 1'b0; d0 = 16'h1234; d1 = '0; y0 = 1'b1; y1 = 1'b0;
    eng_ready = 1'b1; eng_v = 1'b1; eng_d = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(1'b0);                      // inputs active during reset must not leak
    v0 = 1'b0; d0 = '0; y0 = 1'b0; eng_ready = 1'b0; eng_v = 1'b0; eng_d = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single job: 1,2,3,4 in, A,B,C,D back.
    run_job(0, 16'h0001, 16'h000A);
    repeat (2) @(posedge clk); @(negedge clk);
    check_idle(1'b0);

    // Contention from reset, then a second tie after req1 finished.
    do_reset();
    run_pair(16'h0011, 16'h001A, 16'h0021, 16'h002A);
    run_pair(16'h0031, 16'h003A, 16'h0041, 16'h004A);

    // Backpressure on both engine ready and requester yumi.
    bp = 1'b1;
    run_job(0, 16'h0081, 16'h008A);
    bp = 1'b0;
    repeat (2) @(posedge clk); @(negedge clk);
    check_idle(1'b0);

    // Reset in DRAIN after two result words.
    push_job(1, 16'h0051, 16'h005A, 2);
    fork
      req_send(1, 16'h0051);
      begin
        eng_accept(4);
        repeat (10) @(posedge clk);
        eng_return(2);
        @(posedge clk); #1;
        eng_v = 1'b1; eng_d = rx_buf[2] + 16'd9;
      end
      req_recv(1, 2);
    join
    @(negedge clk);
    check("drain_state", dbg_state, DRAIN);
    check("drain_req_v", req_v_o, 2'b10);
    #1 rst_n = 1'b0;
    #1 check_idle(1'b0);
    @(posedge clk); #1;
    eng_v = 1'b0; eng_d = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pair(16'h0061, 16'h006A, 16'h0071, 16'h007A);   // rr pointer back at 0

    // Engine goes silent in WAIT.
    push_job(0, 16'h0091, 16'h009A, 0);
    fork
      req_send(0, 16'h0091);
      eng_accept(4);
    join
`ifdef BSG_CGOL_SCHED_TIMEOUT_EN
    repeat (10) @(negedge clk);
    check("wd_wait_state", dbg_state, WAIT);
    check("wd_error_early", error_o, 0);
    repeat (10) @(negedge clk);
    check("wd_error_set", error_o, 1);
    check_idle(1'b1);
    run_job(1, 16'h00A1, 16'h00AA);
    @(negedge clk);
    check("wd_error_sticky", error_o, 1);
    do_reset();
`else
    repeat (40) @(negedge clk);
    check("hold_wait_state", dbg_state, WAIT);
    check("hold_error", error_o, 0);
    check("hold_grant", grant_o, 2'b01);
    check("hold_eng_yumi", eng_yumi_o, 0);
    do_reset();
`endif

    repeat (2) @(negedge clk);
    check_idle(1'b0);
    check("eng_q_empty", exp_eng_q.size(), 0);
    check("req0_q_empty", exp_req0_q.size(), 0);
    check("req1_q_empty", exp_req1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
